// File: rtl/bb_clk_div_ctrl_pkg.sv
// Shared types and sizing helpers for the BB clock-divider ratio sequencer.
// Optional ramp stepping is selected with BB_CLK_DIV_CTRL_RAMP_EN.
package bb_clk_div_pkg;

  // Sequencer states: accept requests, wait for a divider boundary, let the divider settle
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam int DEFAULT_SETTLE_CYC = 2;

  // Width of a counter that must hold values up to settle_cyc, never narrower than one bit
  function automatic int settle_cnt_wid(input int settle_cyc);
    int w;
    w = $clog2(settle_cyc + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

  localparam int SETTLE_CNT_WID = settle_cnt_wid(DEFAULT_SETTLE_CYC);

endpackage

// File: rtl/bb_clk_div_ctrl_if.sv
// Request/response and divider-side bundle for bb_clk_div_ctrl.
// The master side is the config requester plus the divider's boundary strobe;
// the slave side is the sequencer itself.
interface bb_clk_div_ctrl_if #(
  parameter int RATIO_WID = 8
);

  logic                 req_vld;
  logic [RATIO_WID-1:0] req_ratio;
  logic                 req_rdy;
  logic                 div_en;
  logic [RATIO_WID-1:0] ratio;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output req_vld,
    output req_ratio,
    output div_en,
    input  req_rdy,
    input  ratio,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  req_vld,
    input  req_ratio,
    input  div_en,
    output req_rdy,
    output ratio,
    output busy,
    output done,
    output err
  );

endinterface

// File: rtl/bb_clk_div_ctrl_step.sv
// One-step ratio walker used when BB_CLK_DIV_CTRL_RAMP_EN is defined.
// Moves the current ratio one unit toward the target; the comparison
// guarantees the result never wraps and never reaches zero.
module bb_clk_div_step
  import bb_clk_div_pkg::*;
#(
  parameter int RATIO_WID = 8
) (
  input  logic [RATIO_WID-1:0] ratio,
  input  logic [RATIO_WID-1:0] target,
  output logic [RATIO_WID-1:0] next_ratio
);

  // Step up when below the target, down when above, hold when already there
  always_comb begin
    next_ratio = ratio;
    if (target > ratio) begin
      next_ratio = ratio + 1'b1;
    end else if (target < ratio) begin
      next_ratio = ratio - 1'b1;
    end
  end

endmodule

// File: rtl/bb_clk_div_ctrl.sv
// Ratio-change sequencer for the BB programmable clock divider.
// Accepts ratio requests on a valid/ready handshake and updates the divider's
// ratio only on a div_en boundary so the divided clock never shows a runt.
// Define BB_CLK_DIV_CTRL_RAMP_EN to walk the ratio one step per boundary
// instead of jumping straight to the target.
module bb_clk_div_ctrl
  import bb_clk_div_pkg::*;
#(
  parameter int RATIO_WID   = 8,
  parameter int RESET_RATIO = 1,
  parameter int SETTLE_CYC  = 2
) (
  input  logic              i_clk,
  input  logic              rst_n,
  bb_clk_div_ctrl_if.slave  bus
);

  localparam int                   CNT_WID   = settle_cnt_wid(SETTLE_CYC);
  localparam logic [RATIO_WID-1:0] RESET_VAL = RATIO_WID'(RESET_RATIO);
  localparam logic [CNT_WID-1:0]   CNT_LOAD  = CNT_WID'(SETTLE_CYC - 1);

  state_t               state;
  logic [RATIO_WID-1:0] ratio_q;
  logic [RATIO_WID-1:0] target;
  logic [CNT_WID-1:0]   cnt;
  logic                 rdy_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;

  logic [RATIO_WID-1:0] next_ratio;
  logic                 at_target;
  logic                 handshake;

  assign handshake = bus.req_vld && rdy_q;

`ifdef BB_CLK_DIV_CTRL_RAMP_EN
  bb_clk_div_step #(
    .RATIO_WID (RATIO_WID)
  ) u_step (
    .ratio      (ratio_q),
    .target     (target),
    .next_ratio (next_ratio)
  );

  assign at_target = (ratio_q == target);
`else
  assign next_ratio = target;
  assign at_target  = 1'b1;
`endif

  // Sequencer FSM with every output registered, including the ratio to the divider
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ratio_q <= RESET_VAL;
      target  <= RESET_VAL;
      cnt     <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          rdy_q  <= 1'b1;
          busy_q <= 1'b0;
          if (handshake) begin
            if (bus.req_ratio == '0) begin
              err_q <= 1'b1;
            end else if (bus.req_ratio == ratio_q) begin
              done_q <= 1'b1;
            end else begin
              target <= bus.req_ratio;
              state  <= WAIT;
              rdy_q  <= 1'b0;
              busy_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (bus.div_en) begin
            ratio_q <= next_ratio;
            cnt     <= CNT_LOAD;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (at_target) begin
            state  <= IDLE;
            done_q <= 1'b1;
            rdy_q  <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            state <= WAIT;
          end
        end
        default: begin
          state  <= IDLE;
          rdy_q  <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_rdy = rdy_q;
  assign bus.ratio   = ratio_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_bb_clk_div_ctrl.sv
// Self-checking bench for bb_clk_div_ctrl. Expected ratio/done/busy timing is
// derived from the boundary rules: a step lands on the first edge that samples
// div_en=1 at or after the earliest allowed edge, and done follows the last
// step by SETTLE_CYC cycles. Aware of BB_CLK_DIV_CTRL_RAMP_EN.
module tb_bb_clk_div_ctrl;

  localparam int RATIO_WID   = 8;
  localparam int RESET_RATIO = 1;
  localparam int SETTLE_CYC  = 2;
  localparam int BUDGET      = 3000;

  typedef struct {
    int req;
    int exp_ratio;
  } vec_t;

  logic i_clk = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int passed = 0;
  int model_ratio = RESET_RATIO;
  int cyc = 0;

  bb_clk_div_ctrl_if #(.RATIO_WID(RATIO_WID)) bus ();

  bb_clk_div_ctrl #(
    .RATIO_WID   (RATIO_WID),
    .RESET_RATIO (RESET_RATIO),
    .SETTLE_CYC  (SETTLE_CYC)
  ) dut (
    .i_clk (i_clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock and cycle counter for the periodic div_en pattern
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // div_en pattern: 0 random, 1 held high, 2 one strobe every 4 cycles
  function automatic logic de_pick(input int mode);
    case (mode)
      0:       return ($urandom_range(0, 2) == 0);
      1:       return 1'b1;
      default: return ((cyc % 4) == 3);
    endcase
  endfunction

  task automatic do_reset();
    @(negedge i_clk);
    rst_n = 1'b0;
    bus.req_vld = 1'b0;
    bus.div_en = 1'b0;
    #1;
    check_output("rst_rdy", int'(bus.req_rdy), 0);
    check_output("rst_busy", int'(bus.busy), 0);
    check_output("rst_done", int'(bus.done), 0);
    check_output("rst_err", int'(bus.err), 0);
    check_output("rst_ratio", int'(bus.ratio), RESET_RATIO);
    @(negedge i_clk);
    rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    check_output("post_rst_rdy", int'(bus.req_rdy), 1);
    check_output("post_rst_busy", int'(bus.busy), 0);
    check_output("post_rst_ratio", int'(bus.ratio), RESET_RATIO);
    model_ratio = RESET_RATIO;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int k = 0; k < BUDGET && !seen; k++) begin
      @(posedge i_clk);
      #1;
      if (bus.done) seen = 1;
    end
    if (!seen) check_output({name, "_timeout"}, 0, 1);
  endtask

  // One request, checked cycle by cycle against the boundary rules
  task automatic apply_stimulus(input int r, input int mode);
    int  steps[$];
    int  cur, earliest, last_upd, sidx, fails_before;
    bit  fin, bad, de, exp_done;
    @(negedge i_clk);
    check_output("rdy_before_req", int'(bus.req_rdy), 1);
    bus.req_vld = 1'b1;
    bus.req_ratio = RATIO_WID'(r);
    bus.div_en = de_pick(mode);
    @(posedge i_clk);
    #1;
    if (r == 0 || r == model_ratio) begin
      check_output("imm_err", int'(bus.err), (r == 0) ? 1 : 0);
      check_output("imm_done", int'(bus.done), (r == 0) ? 0 : 1);
      check_output("imm_busy", int'(bus.busy), 0);
      check_output("imm_rdy", int'(bus.req_rdy), 1);
      check_output("imm_ratio", int'(bus.ratio), model_ratio);
      @(negedge i_clk);
      bus.req_vld = 1'b0;
      @(posedge i_clk);
      #1;
      check_output("pulse_err_clear", int'(bus.err), 0);
      check_output("pulse_done_clear", int'(bus.done), 0);
      return;
    end
    check_output("acc_busy", int'(bus.busy), 1);
    check_output("acc_rdy", int'(bus.req_rdy), 0);
    check_output("acc_done", int'(bus.done), 0);
    check_output("acc_ratio", int'(bus.ratio), model_ratio);
`ifdef BB_CLK_DIV_CTRL_RAMP_EN
    cur = model_ratio;
    while (cur != r) begin
      cur += (r > cur) ? 1 : -1;
      steps.push_back(cur);
    end
`else
    steps.push_back(r);
`endif
    earliest = 1;
    sidx = 0;
    last_upd = -1000;
    fin = 0;
    bad = 0;
    for (int e = 1; e <= BUDGET && !fin; e++) begin
      @(negedge i_clk);
      bus.req_vld = 1'b0;
      de = de_pick(mode);
      bus.div_en = de;
      @(posedge i_clk);
      #1;
      if (sidx < steps.size() && e >= earliest && de) begin
        model_ratio = steps[sidx];
        sidx++;
        last_upd = e;
        earliest = e + SETTLE_CYC + 1;
      end
      exp_done = (sidx == steps.size()) && (e == last_upd + SETTLE_CYC);
      fails_before = checks - passed;
      check_output("cyc_ratio", int'(bus.ratio), model_ratio);
      check_output("cyc_done", int'(bus.done), int'(exp_done));
      check_output("cyc_busy", int'(bus.busy), int'(!exp_done));
      check_output("cyc_rdy", int'(bus.req_rdy), int'(exp_done));
      check_output("cyc_err", int'(bus.err), 0);
      if (exp_done) fin = 1;
      if (checks - passed != fails_before) begin
        fin = 1;
        bad = 1;
      end
    end
    if (!fin) check_output("txn_timeout", 0, 1);
    if (bad || !fin) do_reset();
  endtask

  initial begin
    vec_t vecs[9];
    int   r, mode;

    vecs[0] = '{req: 0,   exp_ratio: 1};
    vecs[1] = '{req: 1,   exp_ratio: 1};
    vecs[2] = '{req: 4,   exp_ratio: 4};
    vecs[3] = '{req: 4,   exp_ratio: 4};
    vecs[4] = '{req: 0,   exp_ratio: 4};
    vecs[5] = '{req: 7,   exp_ratio: 7};
    vecs[6] = '{req: 4,   exp_ratio: 4};
    vecs[7] = '{req: 255, exp_ratio: 255};
    vecs[8] = '{req: 1,   exp_ratio: 1};

    bus.req_vld = 1'b0;
    bus.req_ratio = '0;
    bus.div_en = 1'b0;
    do_reset();

    // Table vectors with div_en held high
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i].req, 1);
      check_output("vec_ratio", int'(bus.ratio), vecs[i].exp_ratio);
    end

    // Change 4 -> 6 while the divider strobes every 4 cycles
    apply_stimulus(4, 1);
    apply_stimulus(6, 2);
    check_output("strobe_ratio", int'(bus.ratio), 6);

    // Held request while busy is taken only in the done cycle
    do_reset();
    @(negedge i_clk);
    bus.req_vld = 1'b1;
    bus.req_ratio = 8'd6;
    bus.div_en = 1'b1;
    @(posedge i_clk);
    #1;
    check_output("hold_accept_busy", int'(bus.busy), 1);
    @(negedge i_clk);
    bus.req_ratio = 8'd3;
    begin
      bit seen;
      seen = 0;
      for (int k = 0; k < BUDGET && !seen; k++) begin
        @(posedge i_clk);
        #1;
        if (bus.done) seen = 1;
        else check_output("hold_rdy_low", int'(bus.req_rdy), 0);
      end
      if (!seen) check_output("hold_timeout", 0, 1);
    end
    check_output("hold_done_ratio", int'(bus.ratio), 6);
    check_output("hold_done_rdy", int'(bus.req_rdy), 1);
    @(posedge i_clk);
    #1;
    check_output("hold_second_busy", int'(bus.busy), 1);
    check_output("hold_second_rdy", int'(bus.req_rdy), 0);
    @(negedge i_clk);
    bus.req_vld = 1'b0;
    wait_done("hold_second");
    check_output("hold_second_ratio", int'(bus.ratio), 3);
    model_ratio = 3;

    // Reset while stuck in WAIT (no boundary strobe)
    do_reset();
    @(negedge i_clk);
    bus.req_vld = 1'b1;
    bus.req_ratio = 8'd9;
    bus.div_en = 1'b0;
    @(posedge i_clk);
    #1;
    check_output("wait_busy", int'(bus.busy), 1);
    @(negedge i_clk);
    bus.req_vld = 1'b0;
    @(posedge i_clk);
    #1;
    check_output("wait_ratio_held", int'(bus.ratio), RESET_RATIO);
    do_reset();

    // Reset while in SETTLE
    @(negedge i_clk);
    bus.req_vld = 1'b1;
    bus.req_ratio = 8'd9;
    bus.div_en = 1'b1;
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    bus.req_vld = 1'b0;
    @(posedge i_clk);
    #1;
    check_output("settle_busy", int'(bus.busy), 1);
    check_output("settle_ratio_moved", int'(bus.ratio != RATIO_WID'(RESET_RATIO)), 1);
    do_reset();
    apply_stimulus(5, 1);
    check_output("after_rst_ratio", int'(bus.ratio), 5);

    // Randomized requests and div_en patterns
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 4))
        0:       r = 0;
        1:       r = model_ratio;
        default: r = $urandom_range(1, 12);
      endcase
      mode = $urandom_range(0, 2);
      apply_stimulus(r, mode);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bb_clk_div_ctrl.md
# bb_clk_div_ctrl

Ratio-change sequencer for the BB programmable clock divider. Accepts new divide-ratio requests over a valid/ready handshake and drives the divider's `ratio` input. Changes are applied only at a divided-clock boundary, signalled by the divider's `div_en`, so `o_clk` never shows a runt pulse. Sits between the register/config interface and the divider instance in the BB clocking wrapper.

## Interface
- `RATIO_WID`, 8: width of the ratio bus. Matches the divider.
- `RESET_RATIO`, 1: value of `ratio` out of reset (1 = divider bypass). Must be nonzero.
- `SETTLE_CYC`, 2: `i_clk` cycles held in SETTLE after each ratio update. Must be ≥1.
- `i_clk` input 1: single clock. The divider's input clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_vld` input 1: a ratio change request is present.
- `req_ratio` input RATIO_WID: requested divide ratio.
- `req_rdy` output 1: controller can accept a request. High only in IDLE.
- `div_en` input 1: boundary strobe from the divider.
- `ratio` output RATIO_WID: registered ratio driven to the divider.
- `busy` output 1: state ≠ IDLE.
- `done` output 1: one-cycle pulse when a request completes.
- `err` output 1: one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, WAIT, SETTLE.
- **IDLE**
  - `req_rdy`=1. A handshake (`req_vld` && `req_rdy`) is sampled at the clock edge.
  - `req_ratio`==0: `err` pulses the next cycle. Stay in IDLE; `ratio` unchanged.
  - `req_ratio`==`ratio`: `done` pulses the next cycle. Stay in IDLE; no update.
  - Otherwise: latch `target` <= `req_ratio` and go to WAIT.
- **WAIT**
  - `req_rdy`=0. Hold until `div_en`==1 is sampled.
  - On that edge: `ratio` <= `next_ratio` and go to SETTLE, loading the settle counter with SETTLE_CYC-1.
  - When `ratio`==1 the divider holds `div_en` at 1, so WAIT lasts exactly one cycle.
- **SETTLE**
  - Counter decrements each cycle.
  - At 0 with `ratio`==`target`: go to IDLE and pulse `done`.
  - At 0 with `ratio`≠`target` (ramp builds only): go back to WAIT.
- `next_ratio`:
  - Ramp build: the stepped value; see Configuration.
  - Non-ramp build: `target`.
- Requests offered while `req_rdy`=0 are ignored. The requester must hold `req_vld`. No abort and no queueing.
- `done` and `err` never assert in the same cycle.
- Reset mid-operation: asynchronous return to IDLE. `ratio`=RESET_RATIO, `target`=RESET_RATIO, counter=0.
- Reset values: `req_rdy`=0 while `rst_n`=0, then 1 from the first cycle after release. `busy`=0, `done`=0, `err`=0, `ratio`=RESET_RATIO.

## Timing
- Handshake at edge N:
  - `busy`=1 and `req_rdy`=0 from cycle N+1.
  - The earliest `ratio` update is at edge N+1, if `div_en`=1 in cycle N+1.
- `ratio` is a direct flop output with no combinational path from `req_*`.
- `done` asserts in the first IDLE cycle, together with `req_rdy`=1. A back-to-back request can be accepted in that same cycle.
- Minimum turnaround for a non-ramp change at `div_en`≡1: 1 (WAIT) + SETTLE_CYC cycles, then `done`.
- Reject (`err`) and same-ratio (`done`) responses: 1-cycle latency. `busy` stays 0.
- Steps applied on successive `div_en` strobes are at least SETTLE_CYC+1 cycles apart.

## Configuration
- Macro: `BB_CLK_DIV_CTRL_RAMP_EN`.
- **Defined:**
  - `next_ratio` = `ratio`+1 if `target`>`ratio`, otherwise `ratio`-1.
  - One step per WAIT/SETTLE pass, so a change from 4 to 7 takes 3 boundary-aligned updates.
  - Arithmetic is RATIO_WID-bit. The comparison guarantees no wrap and never produces 0.
- **Undefined:**
  - `next_ratio` = `target`, a single jump.
  - SETTLE always exits to IDLE.
  - The step logic is not compiled.

## Structure
- Package `bb_clk_div_pkg` holds:
  - the state enum (IDLE/WAIT/SETTLE);
  - the settle-counter width localparam, $clog2(SETTLE_CYC+1) with a minimum of 1.
- Sub-module `bb_clk_div_step`: combinational step computation of `ratio`±1 toward `target`. Instantiated only under `BB_CLK_DIV_CTRL_RAMP_EN`.
- The divider instance lives in the parent wrapper, not in this block.

## Test plan
- Reset release with RESET_RATIO=1, then request 4 with `div_en` held at 1 → `ratio`=4 one cycle after accept; `done` pulses SETTLE_CYC cycles later; `busy` low with it.
- `ratio`=4 and `div_en` strobing every 4 cycles; request 6 → `ratio` changes only on the edge that samples `div_en`=1; no `o_clk` runt at the divider output.
- Request 0 → `err` pulse 1 cycle later; `ratio` unchanged; `busy` never asserts. Request equal to the current `ratio` → `done` only.
- Ramp build, 4→7 → `ratio` sequence 5, 6, 7 on three successive strobes, a single `done`. Ramp build, 7→4 → 6, 5, 4.
- Hold `req_vld` with a new value while busy → not accepted until the `done` cycle, then accepted in that same cycle.
- Assert `rst_n`=0 during WAIT and during SETTLE → outputs return immediately to the reset values; the next request is handled normally.
